instr_encode_loader: RTL and testbench

- Converts decoded instruction fields (op, rd, rs1, rs2, func, op_2, immediate) back into 32-bit RV32I instruction words.
- Writes the words sequentially into instruction memory at boot or under test control.
- Sits between a host/debug field source and the imem write port. It is the inverse of the core's field decoder.
- Includes a load FSM, a word-address counter, a registered write stage and sticky error flags.

---
 rtl/instr_encode_loader_if.sv | 39 +++
 rtl/instr_encode_loader.sv | 131 +++++++++++++
 tb/tb_instr_encode_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/instr_encode_loader_if.sv
// Field-bundle / imem-write bus for instr_encode_loader.
// master = host/debug field source and imem sink, slave = the loader.
interface instr_encode_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [6:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_func;
    logic [6:0]        in_op_2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err_op;
    logic              err_imm;
    logic              err_ovf;

    modport master (
        output start, in_valid, in_last, in_op, in_rd, in_rs1, in_rs2,
               in_func, in_op_2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done,
               err_op, err_imm, err_ovf
    );

    modport slave (
        input  start, in_valid, in_last, in_op, in_rd, in_rs1, in_rs2,
               in_func, in_op_2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done,
               err_op, err_imm, err_ovf
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Re-encodes decoded RV32I fields into instruction words and streams them into imem.
// Define ENCODE_CHECK_EN for immediate range/alignment checking with NOP substitution.
module instr_encode_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_encode_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [31:0]       NOP       = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              full_q;
    logic              hs, at_end, is_shift, op_bad, imm_bad;
    logic [31:0]       enc_word, word;

    assign hs       = bus.in_valid && bus.in_ready;
    assign at_end   = (addr_q == LAST_ADDR);
    assign is_shift = (bus.in_op == 7'h13) && ((bus.in_func == 3'd1) || (bus.in_func == 3'd5));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (hs && (bus.in_last || at_end)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == LOAD) && !full_q;
        bus.busy     = (state_q == LOAD);
        bus.done     = (state_q == DONE);
    end

    always_comb begin
        enc_word = NOP;
        op_bad   = 1'b0;
        case (bus.in_op)
            7'h33: enc_word = {bus.in_op_2, bus.in_rs2, bus.in_rs1, bus.in_func, bus.in_rd, bus.in_op};
            7'h03, 7'h67, 7'h13:
                if (is_shift)
                    enc_word = {bus.in_op_2, bus.in_imm[4:0], bus.in_rs1, bus.in_func, bus.in_rd, bus.in_op};
                else
                    enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func, bus.in_rd, bus.in_op};
            7'h23: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_func,
                               bus.in_imm[4:0], bus.in_op};
            7'h63: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_func,
                               bus.in_imm[4:1], bus.in_imm[11], bus.in_op};
            7'h6F: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                               bus.in_rd, bus.in_op};
            7'h37, 7'h17: enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_op};
            default: op_bad = 1'b1;
        endcase
    end

`ifdef ENCODE_CHECK_EN
    function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    always_comb begin
        imm_bad = 1'b0;
        case (bus.in_op)
            7'h03, 7'h67, 7'h13:
                imm_bad = is_shift ? (bus.in_imm[31:5] != '0)
                                   : !in_range(bus.in_imm, -2048, 2047);
            7'h23:        imm_bad = !in_range(bus.in_imm, -2048, 2047);
            7'h63:        imm_bad = !in_range(bus.in_imm, -4096, 4094) || bus.in_imm[0];
            7'h6F:        imm_bad = !in_range(bus.in_imm, -1048576, 1048574) || bus.in_imm[0];
            7'h37, 7'h17: imm_bad = (bus.in_imm[11:0] != '0);
            default:      imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    assign word = (op_bad || imm_bad) ? NOP : enc_word;

    // Write stage: every handshake yields exactly one registered write; the counter saturates at the top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.err_op     <= 1'b0;
            bus.err_imm    <= 1'b0;
            bus.err_ovf    <= 1'b0;
            addr_q         <= '0;
            full_q         <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    addr_q      <= BASE;
                    full_q      <= 1'b0;
                    bus.err_op  <= 1'b0;
                    bus.err_imm <= 1'b0;
                    bus.err_ovf <= 1'b0;
                end
                LOAD: if (hs) begin
                    bus.imem_we    <= 1'b1;
                    bus.imem_addr  <= addr_q;
                    bus.imem_wdata <= word;
                    if (op_bad)  bus.err_op  <= 1'b1;
                    if (imm_bad) bus.err_imm <= 1'b1;
                    if (!at_end) begin
                        addr_q <= addr_q + 1'b1;
                    end else if (!bus.in_last) begin
                        full_q      <= 1'b1;
                        bus.err_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a default-size instance plus an ADDR_W=2 instance for overflow.
module tb_instr_encode_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, valid_a, valid_b, last;
    logic [6:0]  op, op_2;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func;
    logic [31:0] imm;

    int unsigned tests = 0, fails = 0;
    int unsigned wr_a = 0, wr_b = 0, wr_b_zero = 0, done_a = 0, done_b = 0;

    always #5 clk = ~clk;

    instr_encode_loader_if #(.ADDR_W(10)) ia ();
    instr_encode_loader_if #(.ADDR_W(2))  ib ();

    instr_encode_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    instr_encode_loader #(.ADDR_W(2),  .BASE_ADDR(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    assign ia.start = start_a;  assign ib.start = start_b;
    assign ia.in_valid = valid_a; assign ib.in_valid = valid_b;
    assign ia.in_last = last;   assign ib.in_last = last;
    assign ia.in_op = op;       assign ib.in_op = op;
    assign ia.in_rd = rd;       assign ib.in_rd = rd;
    assign ia.in_rs1 = rs1;     assign ib.in_rs1 = rs1;
    assign ia.in_rs2 = rs2;     assign ib.in_rs2 = rs2;
    assign ia.in_func = func;   assign ib.in_func = func;
    assign ia.in_op_2 = op_2;   assign ib.in_op_2 = op_2;
    assign ia.in_imm = imm;     assign ib.in_imm = imm;

    always @(negedge clk) begin
        if (ia.imem_we) wr_a <= wr_a + 1;
        if (ib.imem_we) begin
            wr_b <= wr_b + 1;
            if (ib.imem_addr == '0) wr_b_zero <= wr_b_zero + 1;
        end
        if (ia.done) done_a <= done_a + 1;
        if (ib.done) done_b <= done_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Presents one bundle and returns #1 after the edge it was accepted on; in_valid is left high.
    task automatic send(input logic sel, input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f, input logic [6:0] o2,
                        input logic [31:0] im, input logic l);
        int unsigned n = 0;
        op = o; rd = d; rs1 = s1; rs2 = s2; func = f; op_2 = o2; imm = im; last = l;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        while (!(sel ? ib.in_ready : ia.in_ready) && n < 20) begin
            tick(1);
            n++;
        end
        if (n >= 20) check("hs_timeout", n, 0);
        tick(1);
    endtask

    task automatic check_wr(input logic sel, input string tag, input logic [31:0] a, input logic [31:0] w);
        check({tag, "_we"},   sel ? ib.imem_we : ia.imem_we, 1);
        check({tag, "_addr"}, sel ? 32'(ib.imem_addr) : 32'(ia.imem_addr), a);
        check({tag, "_data"}, sel ? ib.imem_wdata : ia.imem_wdata, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_imm_word, exp_err_imm, exp_beq_odd;
`ifdef ENCODE_CHECK_EN
        exp_imm_word = 32'h0000_0013; exp_err_imm = 1; exp_beq_odd = 32'h0000_0013;
`else
        exp_imm_word = 32'h0000_0093; exp_err_imm = 0; exp_beq_odd = 32'hFE00_0EE3;
`endif
        rst_n = 1'b0; start_a = 0; start_b = 0; valid_a = 0; valid_b = 0; last = 0;
        op = 0; op_2 = 0; rd = 0; rs1 = 0; rs2 = 0; func = 0; imm = 0;
        tick(3);
        check("rst_we", ia.imem_we, 0);
        check("rst_addr", 32'(ia.imem_addr), 0);
        check("rst_wdata", ia.imem_wdata, 0);
        check("rst_flags", {ia.busy, ia.done, ia.err_op, ia.err_imm, ia.err_ovf, ia.in_ready}, 0);
        rst_n = 1'b1;
        tick(1);

        // single addi
        pulse_start(0);
        check("load_busy", ia.busy, 1);
        check("load_ready", ia.in_ready, 1);
        send(0, 7'h13, 1, 0, 0, 0, 0, 5, 1);
        valid_a = 0;
        check_wr(0, "addi", 0, 32'h0050_0093);
        check("addi_done", ia.done, 1);
        tick(1);
        check("after_we", ia.imem_we, 0);
        check("after_done", ia.done, 0);
        check("after_busy", ia.busy, 0);

        // formats back-to-back
        pulse_start(0);
        send(0, 7'h23, 0, 1, 2, 2, 0, 8, 0);                 check_wr(0, "sw", 0, 32'h0020_A423);
        send(0, 7'h63, 0, 0, 0, 0, 0, -4, 0);                check_wr(0, "beq", 1, 32'hFE00_0EE3);
        send(0, 7'h6F, 1, 0, 0, 0, 0, 2048, 0);              check_wr(0, "jal", 2, 32'h0010_00EF);
        send(0, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 1);     check_wr(0, "lui", 3, 32'h1234_52B7);
        valid_a = 0;
        tick(2);
        check("fmt_done_cnt", done_a, 2);
        check("fmt_busy", ia.busy, 0);
        check("fmt_wr_cnt", wr_a, 5);

        // error flags and other encodings
        pulse_start(0);
        send(0, 7'h13, 1, 0, 0, 0, 0, 4096, 0);              check_wr(0, "big_imm", 0, exp_imm_word);
        check("err_imm_set", ia.err_imm, exp_err_imm);
        send(0, 7'h7F, 1, 0, 0, 0, 0, 0, 0);                 check_wr(0, "bad_op", 1, 32'h0000_0013);
        check("err_op_set", ia.err_op, 1);
        send(0, 7'h13, 3, 1, 0, 1, 0, 31, 0);                check_wr(0, "slli", 2, 32'h01F0_9193);
        send(0, 7'h13, 3, 1, 0, 5, 7'h20, 4, 0);             check_wr(0, "srai", 3, 32'h4040_D193);
        send(0, 7'h63, 0, 0, 0, 0, 0, -3, 0);                check_wr(0, "beq_odd", 4, exp_beq_odd);
        send(0, 7'h6F, 0, 0, 0, 0, 0, 1048574, 0);           check_wr(0, "jal_max", 5, 32'h7FFF_F06F);
        send(0, 7'h33, 3, 1, 2, 0, 0, 0, 1);                 check_wr(0, "add", 6, 32'h0020_81B3);
        valid_a = 0;
        tick(2);
        check("err_op_sticky", ia.err_op, 1);
        check("err_imm_sticky", ia.err_imm, exp_err_imm);
        pulse_start(0);
        check("err_clr", {ia.err_op, ia.err_imm, ia.err_ovf}, 0);

        // back-pressure, then reset mid-load
        tick(2);
        check("bp_we", ia.imem_we, 0);
        check("bp_wr_cnt", wr_a, 12);
        send(0, 7'h13, 2, 0, 0, 0, 0, -1, 0);                check_wr(0, "bp0", 0, 32'hFFF0_0113);
        valid_a = 0;
        tick(2);
        check("bp_wr_cnt2", wr_a, 13);
        send(0, 7'h13, 2, 0, 0, 0, 0, 2047, 0);              check_wr(0, "bp1", 1, 32'h7FF0_0113);
        valid_a = 0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_we", ia.imem_we, 0);
        check("mid_rst_busy", ia.busy, 0);
        check("mid_rst_ready", ia.in_ready, 0);
        pulse_start(0);
        send(0, 7'h13, 1, 0, 0, 0, 0, 5, 1);                 check_wr(0, "restart", 0, 32'h0050_0093);
        valid_a = 0;
        tick(2);

        // overflow on the 4-word instance
        pulse_start(1);
        send(1, 7'h13, 1, 0, 0, 0, 0, 1, 0);                 check_wr(1, "ovf0", 0, 32'h0010_0093);
        send(1, 7'h13, 2, 0, 0, 0, 0, 2, 0);                 check_wr(1, "ovf1", 1, 32'h0020_0113);
        send(1, 7'h13, 3, 0, 0, 0, 0, 3, 0);                 check_wr(1, "ovf2", 2, 32'h0030_0193);
        send(1, 7'h13, 4, 0, 0, 0, 0, 4, 0);                 check_wr(1, "ovf3", 3, 32'h0040_0213);
        check("ovf_err", ib.err_ovf, 1);
        check("ovf_done", ib.done, 1);
        check("ovf_ready", ib.in_ready, 0);
        imm = 5; rd = 5; last = 1;
        tick(6);
        check("ovf_wr_cnt", wr_b, 4);
        check("ovf_addr0_cnt", wr_b_zero, 1);
        check("ovf_done_cnt", done_b, 1);
        check("ovf_ready_after", ib.in_ready, 0);
        check("ovf_err_sticky", ib.err_ovf, 1);
        valid_b = 0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
